vga_color_sequencer: RTL and testbench
======================================

// Module: vga_color_sequencer
// PURPOSE
//   Drives the colour input of the solid-colour VGA datapath: steps through a fixed 8-entry RGB565 palette.
//   Frame boundaries come from the timing generator's vsync.
//   Colour changes only at a frame boundary, never mid-frame.
//   Two modes: AUTO advances every FRAMES_PER_COLOR frames; PAUSED holds the colour and advances one entry per key_step.
//   Sits between the key debouncers and the VGA colour datapath, in the same clk domain.
// PARAMETERS
//   FRAMES_PER_COLOR  60  frames shown per colour in AUTO; legal range 1..255; 0 is illegal.
//   VSYNC_ACT_LOW     1   1: vsync pulse is active-low; 0: vsync pulse is active-high.
// PORTS
//   clk         in   1   system/pixel clock; all logic on rising edge.
//   rst_n       in   1   asynchronous, active-low reset.
//   vsync_in    in   1   vsync from timing generator, synchronous to clk.
//   key_mode    in   1   1-cycle pulse (debounced); toggles AUTO <-> PAUSED.
//   key_step    in   1   1-cycle pulse (debounced); requests one advance while PAUSED.
//   color_out   out  16  current RGB565 colour to the datapath.
//   color_idx   out  3   current palette index.
//   frame_tick  out  1   1-cycle pulse marking the start of a frame.
//   paused      out  1   1 while in PAUSED.
// BEHAVIOUR
//   Palette, idx 0..7: F800 red, 07E0 green, 001F blue, FFFF white, 0000 black, FFE0 yellow, 07FF cyan, F81F magenta.
//   Reset values (async):
//     - state AUTO, paused 0, color_idx 0, color_out 16'hF800, frame_tick 0;
//     - frame counter 0, step_pending 0;
//     - vs_d = deasserted level (1 when VSYNC_ACT_LOW=1).
//   Frame edge:
//     - vs_act = VSYNC_ACT_LOW ? ~vsync_in : vsync_in; vs_d is the registered previous vs_act;
//     - edge = vs_act & ~vs_d;
//     - frame_tick is registered: high exactly one cycle, in the cycle after the edge is sampled;
//     - if vsync is asserted when reset releases, that counts as an edge.
//   AUTO, on frame_tick:
//     - if cnt == FRAMES_PER_COLOR-1: cnt <= 0 and idx <= idx+1;
//     - else cnt <= cnt+1.
//   PAUSED:
//     - cnt frozen;
//     - key_step sets step_pending; further steps before the boundary collapse into one;
//     - on frame_tick with step_pending: idx <= idx+1 and step_pending <= 0.
//   key_step in AUTO is ignored.
//   key_mode, highest priority:
//     - state toggles, cnt <= 0, step_pending <= 0;
//     - idx is not advanced in that cycle, even if frame_tick or key_step is high.
//   idx wraps 7 -> 0. cnt is 8 bits.
//   color_idx and color_out update on the same clock edge; color_out is registered from the next-index palette lookup.
//     - latency: frame_tick high in cycle t -> new color_idx/color_out visible in cycle t+1.
//   paused is registered and equals (state == PAUSED).
//   Reset mid-frame: all state returns to reset values immediately; the next vsync edge restarts counting from cnt 0.
//   FSM states: AUTO, PAUSED only; transitions only on key_mode.
// TESTING (bench uses FRAMES_PER_COLOR=2, VSYNC_ACT_LOW=1, short synthetic frames)
//   1. Release reset, vsync high, no keys -> color_out=F800, idx=0, paused=0, no frame_tick.
//   2. Reset/output checks:
//      - 4 vsync low pulses -> frame_tick once per pulse, one cycle after each falling edge;
//      - idx 0->1 at tick 2, 1->2 at tick 4; color_out 07E0, then 001F, one cycle after the tick.
//   3. Run 16 frames in AUTO -> idx visits 0..7 and wraps to 0; color_out back at F800; never changes except one cycle after a tick.
//   4. Pause and step:
//      - key_mode pulse -> paused=1; 6 frames -> idx unchanged;
//      - 3 key_step pulses within one frame -> exactly one advance, at the next frame_tick.
//   5. Priority: key_mode in the same cycle as frame_tick with cnt=1 in AUTO -> paused=1, idx unchanged, cnt=0.
//   6. Assert rst_n low mid-frame while idx=5, PAUSED, step_pending=1 -> immediate idx=0, F800, AUTO; no pending step after release.

Source files
------------

// File: rtl/vga_color_sequencer.sv
// Steps the solid-colour VGA datapath through an 8-entry RGB565 palette, changing colour only
// at vsync frame boundaries, either automatically every FRAMES_PER_COLOR frames or by key_step.
module vga_color_sequencer #(
  parameter int unsigned FRAMES_PER_COLOR = 60,
  parameter bit          VSYNC_ACT_LOW    = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vsync_in,
  input  logic        key_mode,
  input  logic        key_step,
  output logic [15:0] color_out,
  output logic [2:0]  color_idx,
  output logic        frame_tick,
  output logic        paused
);

  typedef enum logic {ST_AUTO = 1'b0, ST_PAUSED = 1'b1} state_e;

  localparam logic       VS_IDLE  = VSYNC_ACT_LOW ? 1'b1 : 1'b0;
  localparam logic [7:0] CNT_LAST = 8'(FRAMES_PER_COLOR - 1);

  function automatic logic [15:0] palette(input logic [2:0] i);
    case (i)
      3'd0:    palette = 16'hF800;
      3'd1:    palette = 16'h07E0;
      3'd2:    palette = 16'h001F;
      3'd3:    palette = 16'hFFFF;
      3'd4:    palette = 16'h0000;
      3'd5:    palette = 16'hFFE0;
      3'd6:    palette = 16'h07FF;
      default: palette = 16'hF81F;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        step_pending_q, step_pending_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] color_q;
  logic        vs_raw_q;
  logic        frame_tick_q;
  logic        vs_act, vs_prev_act, frame_edge;

  // Previous level resets to idle, so vsync already asserted at reset release reads as an edge.
  assign vs_act      = VSYNC_ACT_LOW ? ~vsync_in : vsync_in;
  assign vs_prev_act = VSYNC_ACT_LOW ? ~vs_raw_q : vs_raw_q;
  assign frame_edge  = vs_act & ~vs_prev_act;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_AUTO;
      cnt_q          <= 8'd0;
      step_pending_q <= 1'b0;
      idx_q          <= 3'd0;
      color_q        <= 16'hF800;
      vs_raw_q       <= VS_IDLE;
      frame_tick_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      step_pending_q <= step_pending_d;
      idx_q          <= idx_d;
      color_q        <= palette(idx_d);
      vs_raw_q       <= vsync_in;
      frame_tick_q   <= frame_edge;
    end
  end

  always_comb begin
    state_d = state_q;
    if (key_mode) begin
      state_d = (state_q == ST_AUTO) ? ST_PAUSED : ST_AUTO;
    end
  end

  // key_mode outranks both the frame advance and step requests in the same cycle.
  always_comb begin
    cnt_d          = cnt_q;
    step_pending_d = step_pending_q;
    idx_d          = idx_q;
    if (key_mode) begin
      cnt_d          = 8'd0;
      step_pending_d = 1'b0;
    end else if (state_q == ST_AUTO) begin
      if (frame_tick_q) begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = 8'd0;
          idx_d = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    end else begin
      if (frame_tick_q && step_pending_q) begin
        idx_d          = idx_q + 3'd1;
        step_pending_d = 1'b0;
      end
      if (key_step) begin
        step_pending_d = 1'b1;
      end
    end
  end

  always_comb begin
    color_out  = color_q;
    color_idx  = idx_q;
    frame_tick = frame_tick_q;
    paused     = (state_q == ST_PAUSED);
  end

endmodule

// File: tb/tb_vga_color_sequencer.sv
// Bench for vga_color_sequencer: directed scenarios plus randomized frames and keys, every
// cycle compared against a frame/step-level reference model of the palette sequencer.
module tb_vga_color_sequencer;

  localparam int FPC = 2;
  localparam logic [15:0] PAL [8] = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF,
                                      16'h0000, 16'hFFE0, 16'h07FF, 16'hF81F};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vsync_in = 1'b1;
  logic        key_mode = 1'b0;
  logic        key_step = 1'b0;
  logic [15:0] color_out;
  logic [2:0]  color_idx;
  logic        frame_tick;
  logic        paused;

  int n_pass = 0;
  int n_checks = 0;
  int n_fail = 0;

  // Reference model state
  int idx_m, frames_m;
  bit paused_m, pend_m, tick_m, prev_vs_m;

  vga_color_sequencer #(.FRAMES_PER_COLOR(FPC), .VSYNC_ACT_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .vsync_in(vsync_in), .key_mode(key_mode), .key_step(key_step),
    .color_out(color_out), .color_idx(color_idx), .frame_tick(frame_tick), .paused(paused)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".idx"},   16'(color_idx),  16'(idx_m));
    chk({tag, ".color"}, color_out,       PAL[idx_m]);
    chk({tag, ".tick"},  16'(frame_tick), 16'(tick_m));
    chk({tag, ".pause"}, 16'(paused),     16'(paused_m));
  endtask

  task automatic model_reset();
    idx_m = 0; frames_m = 0; paused_m = 0; pend_m = 0; tick_m = 0; prev_vs_m = 1;
  endtask

  // One clock: inputs are applied, the model advances by the rules, outputs are compared.
  task automatic step(input logic vs, input logic km, input logic ks);
    vsync_in = vs; key_mode = km; key_step = ks;
    @(posedge clk);
    if (km) begin
      paused_m = !paused_m; frames_m = 0; pend_m = 0;
    end else if (!paused_m) begin
      if (tick_m) begin
        frames_m++;
        if (frames_m == FPC) begin
          frames_m = 0; idx_m = (idx_m + 1) % 8;
        end
      end
    end else begin
      if (tick_m && pend_m) begin
        idx_m = (idx_m + 1) % 8; pend_m = 0;
      end
      if (ks) pend_m = 1;
    end
    tick_m = prev_vs_m && !vs;
    prev_vs_m = vs;
    #1;
    check_all("cyc");
    key_mode = 1'b0; key_step = 1'b0;
  endtask

  // A frame is a vsync low pulse of lo cycles followed by hi cycles of visible area.
  task automatic run_frame(input int lo, input int hi);
    for (int i = 0; i < lo; i++) step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < hi; i++) step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input logic vs_at_release);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst.idx",   16'(color_idx),  16'd0);
    chk("rst.color", color_out,       16'hF800);
    chk("rst.pause", 16'(paused),     16'd0);
    chk("rst.tick",  16'(frame_tick), 16'd0);
    vsync_in = vs_at_release; key_mode = 1'b0; key_step = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int saved_idx;
    model_reset();

    // 1: reset release with vsync idle
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
    chk("s1.idx", 16'(color_idx), 16'd0);

    // 2: four frames -> idx 2, blue
    for (int f = 0; f < 4; f++) run_frame(2, 4);
    chk("s2.idx",   16'(color_idx), 16'd2);
    chk("s2.color", color_out,      16'h001F);

    // 3: sixteen more frames wrap all the way round
    for (int f = 0; f < 16; f++) run_frame(1, 3);
    chk("s3.idx", 16'(color_idx), 16'd2);

    // 4: pause, frames do not advance; three steps in one frame give one advance
    step(1'b1, 1'b1, 1'b0);
    chk("s4.paused", 16'(paused), 16'd1);
    for (int f = 0; f < 6; f++) run_frame(1, 3);
    chk("s4.hold", 16'(color_idx), 16'd2);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    run_frame(1, 3);
    run_frame(1, 3);
    chk("s4.step", 16'(color_idx), 16'd3);

    // 5: key_mode coinciding with frame_tick while cnt=1 in AUTO
    step(1'b1, 1'b1, 1'b0);
    run_frame(1, 3);
    saved_idx = idx_m;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("s5.paused", 16'(paused),    16'd1);
    chk("s5.idx",    16'(color_idx), 16'(saved_idx));
    run_frame(1, 3);
    step(1'b1, 1'b1, 1'b0);
    run_frame(1, 3);
    chk("s5.cnt0", 16'(color_idx), 16'(saved_idx));

    // 6: reach idx 5 paused with a step pending, then reset mid-frame
    step(1'b1, 1'b1, 1'b0);
    for (int g = 0; g < 8 && idx_m != 5; g++) begin
      step(1'b1, 1'b0, 1'b1);
      run_frame(1, 3);
    end
    chk("s6.idx5", 16'(color_idx), 16'd5);
    step(1'b1, 1'b0, 1'b1);
    do_reset(1'b1);
    step(1'b1, 1'b1, 1'b0);
    run_frame(1, 3);
    run_frame(1, 3);
    chk("s6.nopend", 16'(color_idx), 16'd0);

    // Reset released with vsync already asserted counts as an edge
    do_reset(1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("rel.tick", 16'(frame_tick), 16'd1);
    run_frame(0, 3);

    // Randomized frames and key activity
    for (int f = 0; f < 120; f++) begin
      int lo, hi;
      lo = $urandom_range(1, 3);
      hi = $urandom_range(2, 8);
      for (int i = 0; i < lo + hi; i++) begin
        step((i < lo) ? 1'b0 : 1'b1,
             ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
             ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
